// File: rtl/fft_pkg.sv
// Shared types for the FFT frame sequencer: FFT-side FSM states and note layout.
package fft_pkg;
  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_START, F_WAIT} fstate_t;

  typedef struct packed {
    logic [3:0] name;
    logic [2:0] octave;
    logic       sharp;
  } note_t;

  // Registered-read latency of the frame buffer.
  localparam int RD_STAGES = 1;
endpackage

// File: rtl/pingpong_ram.sv
// Two-bank frame buffer: one write port, one registered read port, address {bank, idx}.
module pingpong_ram #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [N:0]           waddr,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [N:0]           raddr,
  output logic [BIT_WIDTH-1:0] rdata
);
  logic [BIT_WIDTH-1:0] mem [2**(N+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_frame_seq.sv
// Ping-pong frame sequencer: decimating capture into one bank while the other
// bank streams into the FFT, with load/start handshake, note latch and overrun flag.
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter int FFT_SIZE  = 512,
  parameter int DECIM_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [BIT_WIDTH-1:0] din,
  input  logic [BIT_WIDTH-1:0] tone_din,
  input  logic                 test_mode,
  output logic [N-1:0]         tone_addr,
  input  logic [DECIM_W-1:0]   decim,
  output logic                 fft_load,
  output logic [N-1:0]         fft_addr,
  output logic [BIT_WIDTH-1:0] fft_din,
  output logic                 fft_start,
  input  logic                 fft_done,
  input  logic [7:0]           note_in,
  output logic [7:0]           note,
  output logic                 note_fresh,
  input  logic                 ovr_clr,
  output logic                 overrun
);
  if (FFT_SIZE != 2**N) begin : g_size_chk
    $error("fft_frame_seq: FFT_SIZE must equal 2**N");
  end

  fstate_t              state, state_nx;
  logic [N-1:0]         wr_ptr, rd_ptr;
  logic                 cap_bank;
  logic [DECIM_W-1:0]   dcnt;
  logic                 keep, frame_done, handoff;
  logic                 load_en, start_en, done_ok;
  logic [RD_STAGES:0]   vld_pipe;
  logic [BIT_WIDTH-1:0] ram_q;
  note_t                note_q;

  assign keep       = sample_valid && (dcnt == '0);
  assign frame_done = keep && (&wr_ptr);
  assign handoff    = frame_done && (state == F_IDLE);

  // Capture side: a frame that completes while the FFT side is busy is
  // rewritten in place, so the read bank is never touched.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      cap_bank <= 1'b0;
      dcnt     <= '0;
      overrun  <= 1'b0;
    end else begin
      if (sample_valid) dcnt <= keep ? decim : dcnt - 1'b1;
      if (keep)         wr_ptr <= wr_ptr + 1'b1;
      if (handoff)      cap_bank <= ~cap_bank;
      if (frame_done && !handoff) overrun <= 1'b1;
      else if (ovr_clr)           overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= F_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      F_IDLE:  if (handoff)  state_nx = F_LOAD;
      F_LOAD:  if (&rd_ptr)  state_nx = F_START;
      F_START:               state_nx = F_WAIT;
      F_WAIT:  if (fft_done) state_nx = F_IDLE;
      default:               state_nx = F_IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state == F_LOAD);
    start_en = (state == F_START);
    done_ok  = (state == F_WAIT) && fft_done;
  end

  // Load, address and start are registered so they line up with RAM read data.
  assign vld_pipe[0] = load_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr                 <= '0;
      vld_pipe[RD_STAGES:1]  <= '0;
      fft_addr               <= '0;
      fft_start              <= 1'b0;
      note_q                 <= '0;
      note_fresh             <= 1'b0;
    end else begin
      rd_ptr                 <= load_en ? rd_ptr + 1'b1 : '0;
      vld_pipe[RD_STAGES:1]  <= vld_pipe[RD_STAGES-1:0];
      fft_addr               <= rd_ptr;
      fft_start              <= start_en;
      if (done_ok) note_q    <= note_t'(note_in);
      note_fresh             <= done_ok;
    end
  end

  pingpong_ram #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_ram (
    .clk   (clk),
    .we    (keep),
    .waddr ({cap_bank, wr_ptr}),
    .wdata (test_mode ? tone_din : din),
    .raddr ({~cap_bank, rd_ptr}),
    .rdata (ram_q)
  );

  // RAM output register has no reset; mask it outside load beats.
  assign fft_load  = vld_pipe[RD_STAGES];
  assign fft_din   = fft_load ? ram_q : '0;
  assign tone_addr = wr_ptr;
  assign note      = note_q;
endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: ramp/decimated/tone frames, note latch, overrun, reset abort.
module tb_fft_frame_seq;
  localparam int BW = 16;
  localparam int N  = 9;
  localparam int FS = 512;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset, sample_valid, test_mode, fft_done, ovr_clr;
  logic [BW-1:0] din, tone_din;
  logic [DW-1:0] decim;
  logic [7:0]    note_in;
  logic [N-1:0]  tone_addr, fft_addr;
  logic          fft_load, fft_start, note_fresh, overrun;
  logic [BW-1:0] fft_din;
  logic [7:0]    note;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Tone LUT stand-in: a simple function of the address the DUT presents.
  assign tone_din = 16'hC000 + 16'(tone_addr) * 16'd3;

  fft_frame_seq #(.BIT_WIDTH(BW), .N(N), .FFT_SIZE(FS), .DECIM_W(DW)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .din(din),
    .tone_din(tone_din), .test_mode(test_mode), .tone_addr(tone_addr),
    .decim(decim), .fft_load(fft_load), .fft_addr(fft_addr), .fft_din(fft_din),
    .fft_start(fft_start), .fft_done(fft_done), .note_in(note_in), .note(note),
    .note_fresh(note_fresh), .ovr_clr(ovr_clr), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] expv(input int kind, input int i);
    case (kind)
      0:       return 16'(i);
      1:       return 16'(4 * i);
      2:       return 16'(1000 + i);
      3:       return 16'(32'hC000 + 3 * i);
      default: return 16'(3000 + i);
    endcase
  endfunction

  // Drive n consecutive valid samples; kind 1 drives the raw index (decimated later),
  // kind 3 drives junk on din since the tone source is selected.
  task automatic feed(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      din = (kind == 1) ? 16'(i) : (kind == 3) ? 16'hFFFF : expv(kind, i);
      if (kind == 3) chk("tone_addr", 64'(tone_addr), 64'(i));
      step();
    end
    sample_valid = 1'b0;
    din = '0;
  endtask

  // Entered in the cycle after the completing write; ends in the fft_start cycle.
  task automatic check_frame(input int kind);
    chk("load_lat", 64'(fft_load), 64'(0));
    step();
    for (int i = 0; i < FS; i++) begin
      chk("beat", 64'({fft_load, fft_addr, fft_din}), 64'({1'b1, 9'(i), expv(kind, i)}));
      step();
    end
    chk("start", 64'({fft_start, fft_load}), 64'(2'b10));
  endtask

  function automatic logic [63:0] all_out();
    return 64'({fft_load, fft_start, fft_addr, fft_din, note, note_fresh, overrun, tone_addr});
  endfunction

  initial begin
    logic any_load;
    reset = 1'b1; sample_valid = 1'b0; test_mode = 1'b0; fft_done = 1'b0;
    ovr_clr = 1'b0; din = '0; decim = '0; note_in = '0;
    step(); step();
    chk("reset", all_out(), 64'(0));
    reset = 1'b0;

    // Ramp frame, decim=0
    feed(FS, 0);
    check_frame(0);
    step();
    chk("start_pulse", 64'(fft_start), 64'(0));

    fft_done = 1'b1; note_in = 8'hA9; step(); fft_done = 1'b0; note_in = '0;
    chk("note", 64'({note, note_fresh}), 64'({8'hA9, 1'b1}));
    step();
    chk("fresh_1cyc", 64'({note, note_fresh}), 64'({8'hA9, 1'b0}));
    fft_done = 1'b1; note_in = 8'h55; step(); fft_done = 1'b0;
    chk("idle_done", 64'({note, note_fresh}), 64'({8'hA9, 1'b0}));

    // Overrun: complete a frame while waiting for the FFT
    feed(FS, 2);
    check_frame(2);
    feed(FS, 0);
    chk("overrun", 64'(overrun), 64'(1));
    any_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_load |= fft_load;
      step();
    end
    chk("no_load", 64'(any_load), 64'(0));
    feed(FS - 1, 0);
    sample_valid = 1'b1; ovr_clr = 1'b1; step(); sample_valid = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'(1));
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'(0));
    fft_done = 1'b1; note_in = 8'h3C; step(); fft_done = 1'b0;
    chk("note_wait", 64'({note, note_fresh}), 64'({8'h3C, 1'b1}));

    // Decimation by 4: sample 2044 is the 512th kept one
    decim = 4'd3;
    feed(2045, 1);
    check_frame(1);
    step();
    fft_done = 1'b1; note_in = 8'h12; step(); fft_done = 1'b0;
    chk("note_decim", 64'(note), 64'(8'h12));

    // Drain the decimation counter back to 0, then abort a load with reset
    decim = '0;
    feed(3, 0);
    chk("no_frame", 64'(tone_addr), 64'(0));
    feed(FS, 4);
    chk("load_lat", 64'(fft_load), 64'(0));
    step();
    for (int i = 0; i < 100; i++) begin
      chk("beat", 64'({fft_load, fft_addr, fft_din}), 64'({1'b1, 9'(i), expv(4, i)}));
      step();
    end
    chk("beat100", 64'({fft_load, fft_addr}), 64'({1'b1, 9'd100}));
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_mid", all_out(), 64'(0));
    fft_done = 1'b1; note_in = 8'hEE; step(); fft_done = 1'b0;
    chk("stray_done", 64'({note, note_fresh}), 64'(0));
    feed(FS, 2);
    check_frame(2);
    step();
    fft_done = 1'b1; note_in = 8'h77; step(); fft_done = 1'b0;
    chk("note_after_rst", 64'(note), 64'(8'h77));

    // Test-tone capture
    test_mode = 1'b1;
    feed(FS, 3);
    check_frame(3);
    test_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
